// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of dmem; DMEM_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
// Latency: 2 + dmem busy cycles per access, with one IDLE cycle between accesses; a WAIT timeout aborts the access.
// Backpressure: pN_busywait stalls each requester until its own completion or abort cycle.
module dmem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0]            p0_read,
  input  logic [2:0]            p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_writedata,
  output logic [DATA_WIDTH-1:0] p0_readdata,
  output logic                  p0_busywait,
  input  logic [3:0]            p1_read,
  input  logic [2:0]            p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_writedata,
  output logic [DATA_WIDTH-1:0] p1_readdata,
  output logic                  p1_busywait,
  output logic [3:0]            mem_read,
  output logic [2:0]            mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait,
  output logic                  grant_id,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    req0;
  logic                    req1;
  logic                    win;
  logic [3:0]              sel_read;
  logic [2:0]              sel_write;
  logic [ADDR_WIDTH-1:0]   sel_address;
  logic [DATA_WIDTH-1:0]   sel_writedata;
  logic [3:0]              cmd_read;
  logic [2:0]              cmd_write;
  logic                    cur_rd;
  logic [7:0]              tmo_cnt;
  logic                    done;
  logic                    abort;
  logic                    resp;
  logic                    start;

  assign req0 = p0_read[3] | p0_write[2];
  assign req1 = p1_read[3] | p1_write[2];

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign win = ~req0;
`else
  logic rr_ptr;
  // rr_ptr names the port that wins a tie; a lone requester wins outright.
  assign win = (req0 & req1) ? rr_ptr : req1;
`endif

  always_comb begin
    sel_read      = p0_read;
    sel_write     = p0_write;
    sel_address   = p0_address;
    sel_writedata = p0_writedata;
    if (win) begin
      sel_read      = p1_read;
      sel_write     = p1_write;
      sel_address   = p1_address;
      sel_writedata = p1_writedata;
    end
  end

  // A write enable takes precedence over a read enable on the same port.
  always_comb begin
    cmd_read  = 4'b0000;
    cmd_write = 3'b000;
    if (sel_write[2]) begin
      cmd_write = sel_write;
    end else if (sel_read[3]) begin
      cmd_read = sel_read;
    end
  end

  assign start = (state == IDLE) & (req0 | req1);
  assign done  = (state == WAIT) & ~mem_busywait;
  assign abort = (state == WAIT) & mem_busywait & (tmo_cnt == TMO_LAST);
  assign resp  = done | abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 | req1) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (resp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_read      <= '0;
      mem_write     <= '0;
      mem_address   <= '0;
      mem_writedata <= '0;
      grant_id      <= 1'b0;
      cur_rd        <= 1'b0;
      timeout_err   <= 1'b0;
      tmo_cnt       <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      rr_ptr        <= 1'b0;
`endif
    end else begin
      if (start) begin
        mem_read      <= cmd_read;
        mem_write     <= cmd_write;
        mem_address   <= sel_address;
        mem_writedata <= sel_writedata;
        grant_id      <= win;
        cur_rd        <= cmd_read[3];
      end else if (resp) begin
        mem_read  <= '0;
        mem_write <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        rr_ptr    <= ~grant_id;
`endif
        if (abort) begin
          timeout_err <= 1'b1;
        end
      end
      if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // Only the granted port sees the release; an aborted access returns zero data.
  assign p0_busywait = req0 & ~(resp & ~grant_id);
  assign p1_busywait = req1 & ~(resp & grant_id);
  assign p0_readdata = (done & ~grant_id & cur_rd) ? mem_readdata : '0;
  assign p1_readdata = (done & grant_id & cur_rd) ? mem_readdata : '0;

endmodule
